// File: rtl/mult_pkg.sv
// mult_pkg: shared nibble width and stage-count helpers for the multiplier datapath
package mult_pkg;
  localparam int NIB_W = 4;
  function automatic int nstg(input int width);
    return width / NIB_W;
  endfunction
  function automatic bit width_ok(input int width);
    return width >= NIB_W && width % NIB_W == 0;
  endfunction
endpackage

// File: rtl/pipe_final_adder_cla4.sv
// cla4bit: 4-bit carry-lookahead adder slice
module cla4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p, g;
  logic [4:0] c;
  assign p = a ^ b;
  assign g = a & b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & cin);
  assign sum = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/pipe_final_adder.sv
// pipe_final_adder: nibble-per-stage pipelined carry-propagate adder with valid/ready flow control
module pipe_final_adder
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row_a,
  input  logic [WIDTH-1:0] in_row_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);
  localparam int NSTG = nstg(WIDTH);
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("pipe_final_adder: WIDTH must be a positive multiple of 4");
  end
  // skew regs shift right so the next stage always reads its nibble at bit 0;
  // the deskew reg shifts right with each new nibble inserted at the top
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];
  logic             c_q [NSTG];
  logic             v_q [NSTG];
  logic             advance;
  assign out_valid = v_q[NSTG-1];
  assign advance = ~out_valid | out_ready;
  assign in_ready = advance;
  assign out_sum = s_q[NSTG-1];
  assign out_cout = c_q[NSTG-1];
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, v_in, co;
    logic [NIB_W-1:0] nib;
    if (k == 0) begin : g_head
      assign a_in = in_row_a;
      assign b_in = in_row_b;
      assign s_in = '0;
      assign c_in = in_cin;
      assign v_in = in_valid;
    end else begin : g_body
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign s_in = s_q[k-1];
      assign c_in = c_q[k-1];
      assign v_in = v_q[k-1];
    end
    cla4bit u_cla (
      .a   (a_in[NIB_W-1:0]),
      .b   (b_in[NIB_W-1:0]),
      .cin (c_in),
      .sum (nib),
      .cout(co)
    );
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end else if (advance) begin
        v_q[k] <= v_in;
        c_q[k] <= co;
        a_q[k] <= a_in >> NIB_W;
        b_q[k] <= b_in >> NIB_W;
        s_q[k] <= (s_in >> NIB_W) | (WIDTH'(nib) << (WIDTH - NIB_W));
      end
    end
  end
endmodule

// File: tb/tb_pipe_final_adder.sv
// tb_pipe_final_adder: directed and randomized scoreboard check of pipe_final_adder
module tb_pipe_final_adder;
  localparam int W = 16;
  localparam int NSTG = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_cin = 0;
  logic out_valid, out_ready = 0, out_cout;
  logic [W-1:0] in_row_a = '0, in_row_b = '0, out_sum;
  int errors = 0, checks = 0, n_acc = 0;
  logic [W:0] exp_q [$];
  logic hold = 0;
  logic [W:0] held = '0;

  always #5 clk = ~clk;

  pipe_final_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row_a(in_row_a), .in_row_b(in_row_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard: exact (W+1)-bit sums queued at input transfer, retired in order at output transfer
  always @(negedge clk) begin : monitor
    logic [W:0] e;
    if (!rst_n) begin
      exp_q.delete();
      hold = 0;
      chk("reset out_valid", out_valid, 0);
    end else begin
      chk("in_ready rule", in_ready, !out_valid || out_ready);
      if (hold) chk("stall stable", {out_valid, out_cout, out_sum}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected output", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("scoreboard", {out_cout, out_sum}, e);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_row_a} + {1'b0, in_row_b} + (W+1)'(in_cin));
        n_acc++;
      end
      hold = out_valid && !out_ready;
      held = {out_cout, out_sum};
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    in_row_a = a;
    in_row_b = b;
    in_cin = c;
    in_valid = 1;
  endtask

  task automatic send_wait(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic [W:0] exp);
    int t, lat;
    @(posedge clk); #2;
    drive(a, b, c);
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 50);
    @(posedge clk); #2;
    in_valid = 0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({name, " latency"}, lat, NSTG);
    chk({name, " sum"}, {out_cout, out_sum}, exp);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [W:0] bb [3];
    int t, cyc;
    bb = '{17'h00100, 17'h01000, 17'h1FFFE};
    repeat (2) @(posedge clk);
    #2;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_sum", out_sum, 0);
    chk("rst out_cout", out_cout, 0);
    chk("rst in_ready", in_ready, 1);
    rst_n = 1;
    out_ready = 1;

    send_wait("basic", 16'h1234, 16'h4321, 0, 17'h05555);
    send_wait("ripple", 16'hFFFF, 16'h0000, 1, 17'h10000);

    @(posedge clk); #2; drive(16'h00FF, 16'h0001, 0);
    @(posedge clk); #2; drive(16'h0FFF, 16'h0001, 0);
    @(posedge clk); #2; drive(16'hFFFF, 16'hFFFF, 0);
    @(posedge clk); #2; in_valid = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 20);
    for (int i = 0; i < 3; i++) begin
      chk("b2b valid", out_valid, 1);
      chk("b2b sum", {out_cout, out_sum}, bb[i]);
      @(negedge clk);
    end

    @(posedge clk); #2; out_ready = 0; drive(16'h0F0F, 16'h00F1, 0);
    @(posedge clk); #2; drive(16'h8000, 16'h8000, 0);
    @(posedge clk); #2; in_valid = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) begin
        chk("stall in_ready", in_ready, 0);
        chk("stall sum", {out_cout, out_sum}, 17'h01000);
      end
    end
    chk("stall out_valid", out_valid, 1);
    @(posedge clk); #2; out_ready = 1;
    @(negedge clk);
    chk("release first", {out_valid, out_cout, out_sum}, {1'b1, 17'h01000});
    @(negedge clk);
    chk("release second", {out_valid, out_cout, out_sum}, {1'b1, 17'h10000});

    @(posedge clk); #2; drive(16'hAAAA, 16'h5555, 0);
    @(posedge clk); #2; in_valid = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst in_ready", in_ready, 1);
    @(posedge clk); #2; rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      chk("no ghost result", out_valid, 0);
    end
    send_wait("after reset", 16'h0001, 16'h0001, 0, 17'h00002);

    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      @(posedge clk); #2;
      in_valid = $urandom_range(0, 99) < 70;
      case ($urandom_range(0, 7))
        0: begin in_row_a = '1; in_row_b = '1; end
        1: begin in_row_a = '1; in_row_b = '0; end
        2: begin in_row_a = '0; in_row_b = W'($urandom); end
        default: begin in_row_a = W'($urandom); in_row_b = W'($urandom); end
      endcase
      in_cin = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 99) < 70;
      cyc++;
    end
    chk("random accepted", n_acc >= 10000, 1);
    @(posedge clk); #2;
    in_valid = 0;
    out_ready = 1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("drain empty", exp_q.size(), 0);
    chk("drain out_valid", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
